// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, T-state encoding and the
// control word whose field order the datapath top also uses.
package cpu_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // HALT encodes as 0 so the state register can feed tstate directly
  localparam logic [2:0] ST_HALT = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_T5   = 3'd5;
  localparam logic [2:0] ST_T6   = 3'd6;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic ir_addr_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic out_in;
    logic instr_done;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_tstate_counter.sv
// T-state counter: advances on enable, clears at instruction end, and parks
// in HALT until reset.
module tstate_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       halt_i,
  output logic [2:0] state_o,
  output logic       halted_o
);

  logic [2:0] state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_T1;
    else     state_q <= state_d;
  end

  // T6 and the unused code 7 always wrap to T1 so a bad opcode cannot wedge us
  always_comb begin
    state_d = state_q;
    if (state_q != ST_HALT && en_i) begin
      if (halt_i)                         state_d = ST_HALT;
      else if (clr_i || state_q >= ST_T6) state_d = ST_T1;
      else                                state_d = state_q + 3'd1;
    end
  end

  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALT);

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: decodes {T-state, opcode} into the datapath strobes and
// drives the T-state counter.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic [3:0] opcode,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       ir_addr_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_in,
  output logic       hlt,
  output logic [2:0] tstate,
  output logic       instr_done
);

  logic [2:0] state;
  logic       halted;
  logic       halt_req;
  ctrl_t      cw;
  ctrl_t      cw_g;

  tstate_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (step_en),
    .clr_i    (cw.instr_done),
    .halt_i   (halt_req),
    .state_o  (state),
    .halted_o (halted)
  );

  // Default arm covers HALT plus the T4 NOP for HLT and undefined opcodes
  always_comb begin
    cw = '0;
    casez ({state, opcode})
      {ST_T1, 4'b????}: begin cw.pc_out = 1'b1; cw.mar_in = 1'b1; end
      {ST_T2, 4'b????}: cw.pc_inc = 1'b1;
      {ST_T3, 4'b????}: begin cw.ram_out = 1'b1; cw.ir_in = 1'b1; cw.ir_out = 1'b1; end
      {ST_T4, OP_LDA},
      {ST_T4, OP_ADD},
      {ST_T4, OP_SUB}: begin cw.ir_addr_out = 1'b1; cw.mar_in = 1'b1; end
      {ST_T4, OP_JMP}: begin cw.ir_addr_out = 1'b1; cw.pc_load = 1'b1; cw.instr_done = 1'b1; end
      {ST_T4, OP_LDI}: begin cw.ir_addr_out = 1'b1; cw.a_in = 1'b1; cw.instr_done = 1'b1; end
      {ST_T4, OP_OUT}: begin cw.a_out = 1'b1; cw.out_in = 1'b1; cw.instr_done = 1'b1; end
      {ST_T5, OP_LDA}: begin cw.ram_out = 1'b1; cw.a_in = 1'b1; cw.instr_done = 1'b1; end
      {ST_T5, OP_ADD}: begin cw.ram_out = 1'b1; cw.b_in = 1'b1; end
      {ST_T5, OP_SUB}: begin cw.ram_out = 1'b1; cw.b_in = 1'b1; cw.alu_sub = 1'b1; end
      {ST_T6, OP_ADD}: begin cw.alu_out = 1'b1; cw.a_in = 1'b1; cw.instr_done = 1'b1; end
      {ST_T6, OP_SUB}: begin
        cw.alu_out = 1'b1; cw.a_in = 1'b1; cw.alu_sub = 1'b1; cw.instr_done = 1'b1;
      end
      default: cw.instr_done = (state == ST_T4);
    endcase
  end

  assign halt_req = (state == ST_T4) && (opcode == OP_HLT);
  assign cw_g     = (step_en && !rst) ? cw : '0;

  assign pc_out      = cw_g.pc_out;
  assign pc_inc      = cw_g.pc_inc;
  assign pc_load     = cw_g.pc_load;
  assign mar_in      = cw_g.mar_in;
  assign ram_out     = cw_g.ram_out;
  assign ir_in       = cw_g.ir_in;
  assign ir_out      = cw_g.ir_out;
  assign ir_addr_out = cw_g.ir_addr_out;
  assign a_in        = cw_g.a_in;
  assign a_out       = cw_g.a_out;
  assign b_in        = cw_g.b_in;
  assign alu_out     = cw_g.alu_out;
  assign alu_sub     = cw_g.alu_sub;
  assign out_in      = cw_g.out_in;
  assign instr_done  = cw_g.instr_done;

  assign hlt    = halted && !rst;
  assign tstate = rst ? ST_T1 : state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, then random stimulus
// against a micro-program reference model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, step_en;
  logic [3:0] opcode;
  logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ir_in, ir_out, ir_addr_out;
  logic       a_in, a_out, b_in, alu_out, alu_sub, out_in, hlt, instr_done;
  logic [2:0] tstate;

  control_sequencer dut (
    .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
    .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out), .ir_addr_out(ir_addr_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub),
    .out_in(out_in), .hlt(hlt), .tstate(tstate), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] PCO = 15'h4000, PCI = 15'h2000, PCL = 15'h1000, MAR = 15'h0800;
  localparam logic [14:0] RAMO = 15'h0400, IRI = 15'h0200, IRO = 15'h0100, IRA = 15'h0080;
  localparam logic [14:0] AIN = 15'h0040, AOUT = 15'h0020, BIN = 15'h0010, ALUO = 15'h0008;
  localparam logic [14:0] SUB = 15'h0004, OIN = 15'h0002, DONE = 15'h0001;
  localparam logic [14:0] F1 = PCO | MAR, F2 = PCI, F3 = RAMO | IRI | IRO;

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] op;
    logic [2:0] ts;
    logic [14:0] w;
    logic       h;
  } vec_t;

  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [14:0] uprog[16][6];
  int          ulen[16];

  function automatic logic [14:0] obs();
    return {pc_out, pc_inc, pc_load, mar_in, ram_out, ir_in, ir_out, ir_addr_out,
            a_in, a_out, b_in, alu_out, alu_sub, out_in, instr_done};
  endfunction

  task automatic add(input logic r, input logic e, input logic [3:0] op,
                     input logic [2:0] ts, input logic [14:0] w, input logic h);
    vec_t v;
    v.r = r; v.e = e; v.op = op; v.ts = ts; v.w = w; v.h = h;
    tbl.push_back(v);
  endtask

  task automatic check(input logic r, input logic e, input logic [3:0] op,
                       input logic [2:0] ts, input logic [14:0] w, input logic h,
                       input string tag);
    rst = r; step_en = e; opcode = op;
    @(negedge clk);
    n_cmp++;
    if (tstate !== ts || obs() !== w || hlt !== h) begin
      n_bad++;
      $display("FAIL %s: got tstate=%0d strobes=%h hlt=%b, want tstate=%0d strobes=%h hlt=%b",
               tag, tstate, obs(), hlt, ts, w, h);
    end
    n_cmp++;
    if ($countones({pc_out, ram_out, ir_addr_out, a_out, alu_out}) > 1) begin
      n_bad++;
      $display("FAIL bus_excl(%s): got drivers=%b, want at most one",
               tag, {pc_out, ram_out, ir_addr_out, a_out, alu_out});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int         k;
    bit         halted;
    logic       r, e;
    logic [3:0] op;
    logic [2:0] ets;
    logic [14:0] ew;
    logic       eh;
    logic [3:0] ops[9];

    // Micro-program reference: fetch is shared, execute lists per opcode
    for (int o = 0; o < 16; o++) begin
      for (int s = 0; s < 6; s++) uprog[o][s] = '0;
      uprog[o][0] = F1; uprog[o][1] = F2; uprog[o][2] = F3;
      ulen[o] = 4;
    end
    uprog[4'h0][3] = IRA | MAR; uprog[4'h0][4] = RAMO | AIN; ulen[4'h0] = 5;
    uprog[4'h1][3] = IRA | MAR; uprog[4'h1][4] = RAMO | BIN; uprog[4'h1][5] = ALUO | AIN;
    ulen[4'h1] = 6;
    uprog[4'h2][3] = IRA | MAR; uprog[4'h2][4] = RAMO | BIN | SUB;
    uprog[4'h2][5] = ALUO | AIN | SUB; ulen[4'h2] = 6;
    uprog[4'h3][3] = IRA | PCL;
    uprog[4'h4][3] = IRA | AIN;
    uprog[4'hE][3] = AOUT | OIN;

    // Directed table
    add(1, 1, 4'h0, 1, 0, 0);
    add(0, 1, 4'h0, 1, F1, 0); add(0, 1, 4'h0, 2, F2, 0); add(0, 1, 4'h0, 3, F3, 0);
    add(0, 1, 4'h0, 4, IRA | MAR, 0); add(0, 1, 4'h0, 5, RAMO | AIN | DONE, 0);
    add(0, 1, 4'h2, 1, F1, 0); add(0, 1, 4'h2, 2, F2, 0); add(0, 1, 4'h2, 3, F3, 0);
    add(0, 1, 4'h2, 4, IRA | MAR, 0); add(0, 1, 4'h2, 5, RAMO | BIN | SUB, 0);
    add(0, 1, 4'h2, 6, ALUO | AIN | SUB | DONE, 0);
    add(0, 1, 4'hA, 1, F1, 0); add(0, 1, 4'h5, 2, F2, 0); add(0, 1, 4'hF, 3, F3, 0);
    add(0, 1, 4'h3, 4, IRA | PCL | DONE, 0);
    add(0, 1, 4'h4, 1, F1, 0); add(0, 1, 4'h4, 2, F2, 0); add(0, 1, 4'h4, 3, F3, 0);
    add(0, 1, 4'h4, 4, IRA | AIN | DONE, 0);
    add(0, 1, 4'hE, 1, F1, 0); add(0, 1, 4'hE, 2, F2, 0); add(0, 1, 4'hE, 3, F3, 0);
    add(0, 1, 4'hE, 4, AOUT | OIN | DONE, 0);
    add(0, 1, 4'h1, 1, F1, 0); add(0, 1, 4'h1, 2, F2, 0); add(0, 1, 4'h1, 3, F3, 0);
    add(0, 1, 4'h1, 4, IRA | MAR, 0);
    add(0, 0, 4'h1, 5, 0, 0); add(0, 0, 4'h1, 5, 0, 0); add(0, 0, 4'h1, 5, 0, 0);
    add(0, 1, 4'h1, 5, RAMO | BIN, 0); add(0, 1, 4'h1, 6, ALUO | AIN | DONE, 0);
    add(0, 1, 4'h0, 1, F1, 0); add(0, 1, 4'h0, 2, F2, 0); add(0, 1, 4'h0, 3, F3, 0);
    add(0, 1, 4'h0, 4, IRA | MAR, 0);
    add(1, 1, 4'h0, 1, 0, 0);
    add(0, 1, 4'h7, 1, F1, 0); add(0, 1, 4'h7, 2, F2, 0); add(0, 1, 4'h7, 3, F3, 0);
    add(0, 1, 4'h7, 4, DONE, 0);
    add(0, 1, 4'hF, 1, F1, 0); add(0, 1, 4'hF, 2, F2, 0); add(0, 1, 4'hF, 3, F3, 0);
    add(0, 1, 4'hF, 4, DONE, 0);
    for (int i = 0; i < 20; i++) add(0, 1'(i % 2), 4'hF, 0, 0, 1);
    add(1, 0, 4'hF, 1, 0, 0);
    add(0, 1, 4'h0, 1, F1, 0);

    rst = 1'b1; step_en = 1'b0; opcode = 4'h0;
    @(posedge clk); #1;
    foreach (tbl[i])
      check(tbl[i].r, tbl[i].e, tbl[i].op, tbl[i].ts, tbl[i].w, tbl[i].h,
            $sformatf("vec%0d", i));

    // Random phase; opcode may only change during fetch or while halted
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF, 4'h7, 4'h9};
    k = 0; halted = 0; op = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      r = (i == 0) || ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      if (halted || k < 3) op = ops[$urandom_range(0, 8)];
      if (r)            begin ets = 3'd1; ew = '0; eh = 1'b0; end
      else if (halted)  begin ets = 3'd0; ew = '0; eh = 1'b1; end
      else if (!e)      begin ets = 3'(k + 1); ew = '0; eh = 1'b0; end
      else begin
        ets = 3'(k + 1);
        ew  = uprog[op][k] | ((k == ulen[op] - 1) ? DONE : 15'h0);
        eh  = 1'b0;
      end
      check(r, e, op, ets, ew, eh, $sformatf("rand%0d", i));
      if (r) begin
        k = 0; halted = 0;
      end else if (!halted && e) begin
        if (k == ulen[op] - 1) begin
          if (op == 4'hF) halted = 1;
          else k = 0;
        end else k++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
